descriptor_port_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter that shares the second port (s2) of the 128 x 32 dual-port descriptor memory between the TX and RX scatter-gather DMA descriptor engines. The first port stays dedicated to the Nios II data master. The block accepts single-word writes and fixed-length read bursts, used for 8-word descriptor fetches. It sequences burst addresses into the memory and routes the one-cycle-latency read data back with per-requester `readdatavalid`. Requesters are served round-robin at burst granularity.

---
 rtl/descriptor_port_arbiter_if.sv | 27 ++
 rtl/descriptor_port_arbiter.sv | 135 +++++++++++++
 tb/tb_descriptor_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/descriptor_port_arbiter_if.sv
// Avalon-MM requester port as seen by the descriptor port arbiter.
// One instance per requester (TX and RX descriptor engines).
interface descriptor_port_arbiter_if #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [BURST_W-1:0]  burstcount;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, burstcount, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, burstcount, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/descriptor_port_arbiter.sv
// Shares port s2 of the 128 x 32 descriptor memory between two Avalon-MM
// requesters. Single-beat writes and fixed-length read bursts, served
// round-robin at burst granularity. Memory read latency is one cycle, so the
// per-requester readdatavalid is a registered copy of "read beat issued".
module descriptor_port_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int BURST_W   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    descriptor_port_arbiter_if.slave m0,
    descriptor_port_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata
);
    typedef enum logic [1:0] {IDLE, RBURST, WRITE} state_t;

    state_t               state, state_next;
    logic                 ready;
    logic                 last_grant;   // 1: m1 was granted last
    logic                 owner;        // requester owning the current command
    logic [BURST_W-1:0]   beats_left;   // beats still to issue after the current one
    logic                 rdv0, rdv1;
    logic                 req0, req1, gnt0, gnt1, accept;
    logic                 sel_write;
    logic [ADDR_W-1:0]    sel_address;
    logic [BURST_W-1:0]   sel_bc, sel_len;
    logic [DATA_W/8-1:0]  sel_byteenable;
    logic [DATA_W-1:0]    sel_writedata;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;
    assign accept = gnt0 | gnt1;

    // Write wins over read when both are asserted.
    assign sel_write      = gnt1 ? m1.write      : m0.write;
    assign sel_address    = gnt1 ? m1.address    : m0.address;
    assign sel_bc         = gnt1 ? m1.burstcount : m0.burstcount;
    assign sel_byteenable = gnt1 ? m1.byteenable : m0.byteenable;
    assign sel_writedata  = gnt1 ? m1.writedata  : m0.writedata;

    // Burst length: 0 behaves as 1, anything above MAX_BURST is clamped.
    assign sel_len = (sel_bc == '0) ? BURST_W'(1)
                   : (sel_bc > BURST_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                   : sel_bc;

    assign m0.waitrequest   = ~gnt0;
    assign m1.waitrequest   = ~gnt1;
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
    assign m0.readdatavalid = rdv0;
    assign m1.readdatavalid = rdv1;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Arbitration and next-state: grant only when idle and out of reset.
    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        unique case (state)
            IDLE: begin
                if (ready) begin
                    if (req0 && (!req1 || last_grant)) gnt0 = 1'b1;
                    else if (req1)                     gnt1 = 1'b1;
                    if (req0 || req1)
                        state_next = (gnt1 ? m1.write : m0.write) ? WRITE : RBURST;
                end
            end
            RBURST:  if (beats_left == '0) state_next = IDLE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch, memory port sequencing and read-return valids.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready          <= 1'b0;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            beats_left     <= '0;
            rdv0           <= 1'b0;
            rdv1           <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
        end else begin
            ready <= 1'b1;
            rdv0  <= mem_chipselect & ~mem_write & ~owner;
            rdv1  <= mem_chipselect & ~mem_write & owner;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant     <= gnt1;
                        owner          <= gnt1;
                        mem_address    <= sel_address;
                        mem_chipselect <= 1'b1;
                        mem_write      <= sel_write;
                        beats_left     <= sel_len - BURST_W'(1);
                        if (sel_write) begin
                            mem_byteenable <= sel_byteenable;
                            mem_writedata  <= sel_writedata;
                        end
                    end
                end
                RBURST: begin
                    if (beats_left != '0) begin
                        mem_address <= mem_address + ADDR_W'(1);
                        beats_left  <= beats_left - BURST_W'(1);
                    end else begin
                        mem_chipselect <= 1'b0;
                    end
                end
                WRITE: begin
                    mem_chipselect <= 1'b0;
                    mem_write      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_descriptor_port_arbiter.sv
// Bench for descriptor_port_arbiter: a one-cycle-latency RAM model on the
// memory side, directed vectors, a round-robin sequence, reset mid-burst and
// randomized traffic from both requesters, all checked against a
// transaction-level model of the arbiter.
module tb_descriptor_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  mem_address;
    logic        mem_chipselect, mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata, mem_readdata;

    descriptor_port_arbiter_if #(.ADDR_W(7), .DATA_W(32), .BURST_W(4)) m0_if ();
    descriptor_port_arbiter_if #(.ADDR_W(7), .DATA_W(32), .BURST_W(4)) m1_if ();

    descriptor_port_arbiter #(.ADDR_W(7), .DATA_W(32), .BURST_W(4), .MAX_BURST(8)) dut (
        .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int rel_edges = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Clock edges seen since reset release; the port is usable from the second.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rel_edges <= 0;
        else if (rel_edges < 3) rel_edges <= rel_edges + 1;
    end

    function automatic logic [31:0] init_word(input int i);
        if (i >= 16 && i < 24) return 32'(160 + i - 16);
        if (i == 64) return 32'h1122_3344;
        return 32'h5A5A_0000 | 32'(i);
    endfunction

    // Memory: address registered on chipselect, unregistered q.
    logic [31:0] ram [128];
    logic [6:0]  ram_q_addr = '0;
    logic        do_preload = 1'b0;
    assign mem_readdata = ram[ram_q_addr];

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 128; i++) ram[i] <= init_word(i);
        end else if (mem_chipselect) begin
            ram_q_addr <= mem_address;
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct { int cyc; logic [6:0] addr; bit wr; logic [3:0] be; logic [31:0] wd; } iss_t;
    typedef struct { int cyc; logic [31:0] data; } ret_t;

    iss_t        iss_q[$];
    ret_t        rdq0[$], rdq1[$];
    bit          grant_log[$];
    logic [31:0] model_mem [128];
    bit          mdl_init = 1'b0;
    bit          mdl_last = 1'b1;
    int          free_cyc = 0;
    int          beats_seen[2] = '{0, 0};
    logic [31:0] last_rdata[2];
    logic [6:0]  last_issue_addr;

    always @(negedge clk) begin : monitor
        logic r0, r1, acc, win, due, v, has, w;
        logic [6:0] a, ad;
        logic [3:0] bc, be;
        logic [31:0] wd, rd;
        iss_t ie;
        ret_t fr;
        int n;
        if (!reset_n) begin
            if (!mdl_init) begin
                for (int i = 0; i < 128; i++) model_mem[i] = init_word(i);
                mdl_init = 1'b1;
            end
            check("reset_outputs",
                  {m0_if.waitrequest, m1_if.waitrequest, mem_chipselect, mem_write,
                   m0_if.readdatavalid, m1_if.readdatavalid, mem_address},
                  {2'b11, 4'b0000, 7'h00});
            iss_q.delete(); rdq0.delete(); rdq1.delete();
            free_cyc = 0;
            mdl_last = 1'b1;
        end else begin
            // memory port issue stream
            due = (iss_q.size() > 0) && (iss_q[0].cyc <= cyc);
            if (mem_chipselect || due) begin
                check("issue_due", mem_chipselect, due);
                if (mem_chipselect && due) begin
                    ie = iss_q[0];
                    check("issue_addr", mem_address, ie.addr);
                    check("issue_write", mem_write, ie.wr);
                    if (ie.wr) begin
                        check("issue_be", mem_byteenable, ie.be);
                        check("issue_wdata", mem_writedata, ie.wd);
                    end
                end
                if (mem_chipselect) last_issue_addr = mem_address;
                if (due) void'(iss_q.pop_front());
            end
            // read return per requester
            for (int m = 0; m < 2; m++) begin
                v  = (m == 1) ? m1_if.readdatavalid : m0_if.readdatavalid;
                rd = (m == 1) ? m1_if.readdata : m0_if.readdata;
                if (m == 0) begin has = rdq0.size() > 0; if (has) fr = rdq0[0]; end
                else        begin has = rdq1.size() > 0; if (has) fr = rdq1[0]; end
                due = has && (fr.cyc <= cyc);
                if (v || due) begin
                    check($sformatf("rdv%0d_due", m), v, due);
                    if (v && due) check($sformatf("rdv%0d_data", m), rd, fr.data);
                    if (v) begin beats_seen[m]++; last_rdata[m] = rd; end
                    if (due) begin
                        if (m == 0) void'(rdq0.pop_front());
                        else        void'(rdq1.pop_front());
                    end
                end
            end
            // arbitration: free, out of reset, not-last-granted wins a tie
            r0  = m0_if.read | m0_if.write;
            r1  = m1_if.read | m1_if.write;
            acc = (rel_edges >= 1) && (cyc >= free_cyc) && (r0 || r1);
            win = (r0 && r1) ? ~mdl_last : r1;
            if (r0 || r1)
                check("waitrequest", {m0_if.waitrequest, m1_if.waitrequest},
                      {~(acc & ~win), ~(acc & win)});
            if (acc) begin
                grant_log.push_back(win);
                mdl_last = win;
                a  = win ? m1_if.address    : m0_if.address;
                bc = win ? m1_if.burstcount : m0_if.burstcount;
                be = win ? m1_if.byteenable : m0_if.byteenable;
                wd = win ? m1_if.writedata  : m0_if.writedata;
                w  = win ? m1_if.write      : m0_if.write;
                if (w) begin
                    iss_q.push_back(iss_t'{cyc + 1, a, 1'b1, be, wd});
                    for (int b = 0; b < 4; b++)
                        if (be[b]) model_mem[a][8*b +: 8] = wd[8*b +: 8];
                    free_cyc = cyc + 2;
                end else begin
                    n = (bc == 0) ? 1 : (bc > 8) ? 8 : int'(bc);
                    for (int k = 0; k < n; k++) begin
                        ad = 7'((int'(a) + k) % 128);
                        iss_q.push_back(iss_t'{cyc + 1 + k, ad, 1'b0, 4'h0, 32'h0});
                        if (win) rdq1.push_back(ret_t'{cyc + 2 + k, model_mem[ad]});
                        else     rdq0.push_back(ret_t'{cyc + 2 + k, model_mem[ad]});
                    end
                    free_cyc = cyc + 1 + n;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic set_cmd(input int m, input bit rd, input bit wr, input logic [6:0] a,
                           input logic [3:0] bc, input logic [3:0] be, input logic [31:0] wd);
        if (m == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
            m0_if.burstcount = bc; m0_if.byteenable = be; m0_if.writedata = wd;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
            m1_if.burstcount = bc; m1_if.byteenable = be; m1_if.writedata = wd;
        end
    endtask

    // Present a command, hold it until accepted, then drop it.
    task automatic do_cmd(input int m, input bit rd, input bit wr, input logic [6:0] a,
                          input logic [3:0] bc, input logic [3:0] be, input logic [31:0] wd);
        int t = 0;
        @(posedge clk); #1;
        set_cmd(m, rd, wr, a, bc, be, wd);
        forever begin
            @(negedge clk); #1;
            if (((m == 1) ? m1_if.waitrequest : m0_if.waitrequest) == 1'b0) break;
            t++;
            if (t > 200) begin check("accept_timeout_cycles", t, 200); break; end
        end
        @(posedge clk); #1;
        set_cmd(m, 1'b0, 1'b0, 7'h00, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(rdq0.size() == 0 && rdq1.size() == 0 && iss_q.size() == 0 && cyc >= free_cyc)) begin
            @(negedge clk); #1;
            t++;
            if (t > 300) begin check("idle_timeout_cycles", t, 300); break; end
        end
        @(negedge clk); #1;
    endtask

    task automatic rand_cmd(input int m);
        int op;
        op = $urandom_range(0, 2);
        do_cmd(m, op != 1, op != 0, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), $urandom);
    endtask

    typedef struct {
        int m; bit rd; bit wr; logic [6:0] addr; logic [3:0] bc; logic [3:0] be;
        logic [31:0] wd; int beats; logic [6:0] last_addr; logic [31:0] last_data;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int b, gl0;
        //            m  rd wr addr   bc  be    wd            beats last   last_data
        vecs[0] = '{1, 1, 0, 7'h7E, 12, 4'hF, 32'h0,        8, 7'h05, 32'h5A5A_0005};
        vecs[1] = '{1, 1, 0, 7'h20,  0, 4'hF, 32'h0,        1, 7'h20, 32'h5A5A_0020};
        vecs[2] = '{0, 1, 0, 7'h30,  3, 4'hF, 32'h0,        3, 7'h32, 32'h5A5A_0032};
        vecs[3] = '{1, 0, 1, 7'h40,  5, 4'h3, 32'hDEADBEEF, 0, 7'h40, 32'h0};
        vecs[4] = '{0, 1, 0, 7'h40,  1, 4'hF, 32'h0,        1, 7'h40, 32'h1122_BEEF};
        vecs[5] = '{0, 1, 0, 7'h7F, 15, 4'hF, 32'h0,        8, 7'h06, 32'h5A5A_0006};
        vecs[6] = '{0, 1, 1, 7'h50,  4, 4'hF, 32'h01020304, 0, 7'h50, 32'h0};
        vecs[7] = '{1, 1, 0, 7'h4F,  2, 4'hF, 32'h0,        2, 7'h50, 32'h0102_0304};

        // Reset release with m0 already requesting an 8-word fetch.
        reset_n = 1'b0;
        do_preload = 1'b1;
        set_cmd(0, 1'b1, 1'b0, 7'h10, 4'd8, 4'hF, 32'h0);
        set_cmd(1, 1'b0, 1'b0, 7'h00, 4'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 do_preload = 1'b0;
        @(negedge clk); #2 reset_n = 1'b1;
        #1 check("wr_m0_before_first_edge", m0_if.waitrequest, 1'b1);
        check("cs_before_accept", mem_chipselect, 1'b0);
        @(posedge clk); @(negedge clk); #1;
        check("wr_m0_after_first_edge", m0_if.waitrequest, 1'b0);
        b = beats_seen[0];
        @(posedge clk); #1 set_cmd(0, 1'b0, 1'b0, 7'h00, 4'h0, 4'h0, 32'h0);
        wait_idle();
        check("m0_burst_beats", beats_seen[0] - b, 8);
        check("m0_burst_last_addr", last_issue_addr, 7'h17);
        check("m0_burst_last_data", last_rdata[0], 32'hA7);
        check("m1_no_beats", beats_seen[1], 0);

        // Directed vectors.
        for (int i = 0; i < NV; i++) begin
            b = beats_seen[vecs[i].m];
            do_cmd(vecs[i].m, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].bc, vecs[i].be, vecs[i].wd);
            wait_idle();
            check($sformatf("vec%0d_beats", i), beats_seen[vecs[i].m] - b, vecs[i].beats);
            check($sformatf("vec%0d_last_addr", i), last_issue_addr, vecs[i].last_addr);
            if (vecs[i].beats > 0)
                check($sformatf("vec%0d_last_data", i), last_rdata[vecs[i].m], vecs[i].last_data);
        end

        // Both requesters contending continuously: grants must alternate from m0.
        gl0 = grant_log.size();
        fork
            begin for (int j = 0; j < 4; j++) do_cmd(0, 1'b1, 1'b0, 7'(8'h60 + j), 4'd2, 4'hF, 32'h0); end
            begin for (int j = 0; j < 4; j++) do_cmd(1, 1'b1, 1'b0, 7'(8'h68 + j), 4'd2, 4'hF, 32'h0); end
        join
        wait_idle();
        check("rr_grant_count", grant_log.size() - gl0, 8);
        for (int i = 0; i < 8 && gl0 + i < grant_log.size(); i++)
            check($sformatf("rr_grant%0d", i), grant_log[gl0 + i], i % 2);

        // Reset after the third beat of an 8-beat read.
        b = beats_seen[0];
        do_cmd(0, 1'b1, 1'b0, 7'h10, 4'd8, 4'hF, 32'h0);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            if (beats_seen[0] - b >= 3) break;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        #1 check("midburst_beats_after_reset", beats_seen[0] - b, 3);
        b = beats_seen[1];
        do_cmd(1, 1'b1, 1'b0, 7'h7E, 4'd2, 4'hF, 32'h0);
        wait_idle();
        check("post_reset_m1_beats", beats_seen[1] - b, 2);
        check("post_reset_m1_data", last_rdata[1], 32'h5A5A_007F);

        // Randomized traffic from both requesters.
        fork
            begin
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    rand_cmd(0);
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    rand_cmd(1);
                end
            end
        join
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
